// File: rtl/sb_split_slave.sv
// sb_split_slave -- bus slave with a fast region and a slow, split-capable region.
//
// Fast accesses (addr[11] = 0) complete in one data-phase cycle with OKAY.
// Slow accesses (addr[11] = 1) are handled by a single split slot:
//   S_IDLE : a slow access gets SPLIT; its master is masked for SPLIT_LAT cycles.
//   S_WAIT : the owner is masked; other slow accesses get RETRY.
//   S_DONE : the owner's retry completes with OKAY; others still get RETRY.
// Both regions share one 256 x 32 word array indexed by addr[9:2].
//
// Ports
//   sb_clk, sb_reset          clock, asynchronous active-high reset
//   sb_sel, sb_addr, sb_trans, sb_write, sb_wdata, sb_ready, sb_masters
//                             address/data phase inputs from the bus
//   sb_rdata                  read data (valid in an OKAY read data phase)
//   sb_ready_sl, sb_resp_sl   slave ready / response (00 OKAY, 10 RETRY, 11 SPLIT)
//   sb_split_sl               split mask to arbiter (bit0 master 1, bit1 master 2)
module sb_split_slave #(
  parameter int unsigned SPLIT_LAT = 8
) (
  input  logic        sb_clk,
  input  logic        sb_reset,
  input  logic        sb_sel,
  input  logic [31:0] sb_addr,
  input  logic [1:0]  sb_trans,
  input  logic        sb_write,
  input  logic [31:0] sb_wdata,
  input  logic        sb_ready,
  input  logic        sb_masters,
  output logic [31:0] sb_rdata,
  output logic        sb_ready_sl,
  output logic [1:0]  sb_resp_sl,
  output logic [1:0]  sb_split_sl
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} slot_state_t;

  logic [31:0] mem [0:255];

  slot_state_t state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;

  // Data-phase registers captured from the accepted address phase.
  logic        dp_valid_reg;
  logic        dp_write_reg;
  logic        dp_owner_reg;
  logic        dp_slow_reg;
  logic [7:0]  dp_word_reg;

  // Second cycle of a two-cycle (RETRY/SPLIT) response.
  logic        resp2_reg;
  logic [1:0]  resp2_code_reg;

  logic [31:0] rd_data_reg;

  logic        addr_accept;
  logic        dp_okay;
  logic        dp_two;
  logic [1:0]  dp_code;
  logic        mem_we;
  logic        unused_bits;

  assign addr_accept = sb_sel & sb_trans[1] & sb_ready;
  assign mem_we      = dp_okay & dp_write_reg;
  assign unused_bits = ^{sb_addr[31:12], sb_addr[10], sb_addr[1:0], sb_trans[0]};

  // Slot FSM next state plus the data-phase response decision.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    dp_okay    = 1'b0;
    dp_two     = 1'b0;
    dp_code    = RESP_OKAY;

    // The split timer runs independently of any data phase, so an expiry
    // coinciding with a non-owner RETRY still moves the slot to S_DONE.
    if (state_reg == S_WAIT) begin
      if (cnt_reg <= 8'd1) begin
        cnt_next   = 8'd0;
        state_next = S_DONE;
      end else begin
        cnt_next = cnt_reg - 8'd1;
      end
    end

    if (dp_valid_reg) begin
      if (!dp_slow_reg) begin
        dp_okay = 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            dp_two     = 1'b1;
            dp_code    = RESP_SPLIT;
            state_next = S_WAIT;
            cnt_next   = SPLIT_LAT[7:0];
            owner_next = dp_owner_reg;
          end
          S_DONE: begin
            if (dp_owner_reg == owner_reg) begin
              dp_okay    = 1'b1;
              state_next = S_IDLE;
            end else begin
              dp_two  = 1'b1;
              dp_code = RESP_RETRY;
            end
          end
          default: begin
            // S_WAIT: the slot is busy; anyone reaching here retries.
            dp_two  = 1'b1;
            dp_code = RESP_RETRY;
          end
        endcase
      end
    end
  end

  always_comb begin
    sb_ready_sl = 1'b1;
    sb_resp_sl  = RESP_OKAY;
    if (resp2_reg) begin
      sb_resp_sl = resp2_code_reg;
    end else if (dp_two) begin
      sb_ready_sl = 1'b0;
      sb_resp_sl  = dp_code;
    end
  end

  // Mask only the owner, and only while waiting: at most one bit set.
  assign sb_split_sl = (state_reg == S_WAIT) ? (owner_reg ? 2'b01 : 2'b10) : 2'b00;
  assign sb_rdata    = rd_data_reg;

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 8'd0;
      owner_reg      <= 1'b0;
      dp_valid_reg   <= 1'b0;
      dp_write_reg   <= 1'b0;
      dp_owner_reg   <= 1'b0;
      dp_slow_reg    <= 1'b0;
      dp_word_reg    <= 8'd0;
      resp2_reg      <= 1'b0;
      resp2_code_reg <= RESP_OKAY;
      rd_data_reg    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      dp_valid_reg   <= addr_accept;
      resp2_reg      <= dp_two;
      resp2_code_reg <= dp_code;
      if (addr_accept) begin
        dp_write_reg <= sb_write;
        dp_owner_reg <= sb_masters;
        dp_slow_reg  <= sb_addr[11];
        dp_word_reg  <= sb_addr[9:2];
        if (!sb_write) begin
          // A write completing on this same edge is not yet in the array.
          if (mem_we && (dp_word_reg == sb_addr[9:2])) begin
            rd_data_reg <= sb_wdata;
          end else begin
            rd_data_reg <= mem[sb_addr[9:2]];
          end
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge sb_clk) begin
    if (mem_we) begin
      mem[dp_word_reg] <= sb_wdata;
    end
  end

endmodule

// File: doc/sb_split_slave.md
SB_SPLIT_SLAVE -- requirements
Module: sb_split_slave

Interface
REQ-001 Parameter SPLIT_LAT, default 8, range 1..255: cycles a split slot stays masked before the master may retry.
REQ-002 sb_clk  in  1  single clock; all state updates on rising edge.
REQ-003 sb_reset  in  1  asynchronous, active-high reset.
REQ-004 sb_sel  in  1  slave select from address decoder.
REQ-005 sb_addr  in  32  transfer address; bits [9:2] index a word, bit 11 = 1 marks the slow region.
REQ-006 sb_trans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 sb_write  in  1  1 = write, 0 = read.
REQ-008 sb_wdata  in  32  write data, valid in the data phase.
REQ-009 sb_ready  in  1  bus ready; an address phase is accepted only when high.
REQ-010 sb_masters  in  1  current bus owner; 1 = master 1, 0 = master 2.
REQ-011 sb_rdata  out  32  read data.
REQ-012 sb_ready_sl  out  1  slave ready.
REQ-013 sb_resp_sl  out  2  response: 00 OKAY, 10 RETRY, 11 SPLIT.
REQ-014 sb_split_sl  out  2  split mask to arbiter; bit0 = master 1, bit1 = master 2; a set bit blocks that master.

Function
REQ-015 Accept an address phase when sb_sel & sb_trans[1] & sb_ready; register address, write, owner and region for the data phase.
REQ-016 IDLE, BUSY or unselected cycles: OKAY, zero wait, no state change.
REQ-017 Memory: 256 x 32 words, not reset; written in the data phase from sb_wdata on OKAY writes only.
REQ-018 Reads: sb_rdata = mem[word] during the OKAY data phase; a read directly after a write to the same word returns the new data (forwarded).
REQ-019 Fast region (bit11 = 0): OKAY with sb_ready_sl = 1 in the first data-phase cycle.
REQ-020 Slot FSM states: S_IDLE, S_WAIT, S_DONE.
REQ-021 S_IDLE + slow access: two-cycle SPLIT response (cycle 1 ready=0 resp=11; cycle 2 ready=1 resp=11); no memory write; capture owner; go to S_WAIT on cycle 2.
REQ-022 S_WAIT: owner split bit high for exactly SPLIT_LAT cycles, starting with response cycle 2; counter loaded with SPLIT_LAT and decremented each cycle; at 0, clear the bit and go to S_DONE.
REQ-023 S_WAIT or S_DONE + slow access from a non-owner: two-cycle RETRY (ready=0 resp=10, then ready=1 resp=10); no write; the slot is unchanged.
REQ-024 S_DONE + slow access from the owner: OKAY zero wait, read/write performed, return to S_IDLE.
REQ-025 Simultaneous events: counter expiry in the same cycle as a non-owner slow access gives RETRY; the transition to S_DONE still happens.
REQ-026 Only one split slot: sb_split_sl never has both bits set.
REQ-027 Between transfers, outputs rest at ready=1, resp=00.

Reset
REQ-028 On sb_reset (asynchronous): sb_ready_sl=1, sb_resp_sl=00, sb_split_sl=00, sb_rdata=0, FSM=S_IDLE, counter=0, data-phase registers cleared; this also applies mid-response or mid-split.
REQ-029 Release is synchronous to sb_clk; the first accepted address phase may occur on the first edge after deassertion.

Verification
REQ-030 Fast write 0x0000_0010 = 0xDEAD_BEEF, then read the same address -> both OKAY zero wait; read returns 0xDEAD_BEEF (forwarding path).
REQ-031 Master 1 reads 0x0000_0800 with SPLIT_LAT=8 -> ready 0/1 with resp 11,11; sb_split_sl=01 for 8 cycles, then 00; retry by master 1 -> OKAY.
REQ-032 Master 1 split pending; master 2 reads 0x0000_0804 -> resp 10 (ready 0 then 1); sb_split_sl stays 01.
REQ-033 Master 1 split write to 0x0000_0808 of 0x1234_5678 -> memory unchanged until the retry in S_DONE; a later read returns 0x1234_5678.
REQ-034 Assert sb_reset during response cycle 1 of a SPLIT -> outputs immediately ready=1, resp=00, split=00, with no clock edge needed.
REQ-035 Counter expiry in the same cycle as a master 2 slow access -> RETRY to master 2; FSM goes to S_DONE; master 1 retry then gets OKAY.
